// File: rtl/updown_seq_pkg.sv
// Shared types for the up/down sequence controller: FSM state encoding and direction constants.
// No logic, no latency; no backpressure.
package updown_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter.sv
// WIDTH-bit synchronous up/down counter with load, enable and direction; wraps modulo 2^WIDTH.
// Q updates one cycle after Ld/En; no backpressure, load has priority over counting.
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Ld,
  input  logic [WIDTH-1:0] Ld_val,
  input  logic             En,
  input  logic             Up,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q <= '0;
    end else if (Ld) begin
      Q <= Ld_val;
    end else if (En) begin
      Q <= Up ? (Q + ONE) : (Q - ONE);
    end
  end

endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequenced up/down count from Load to Limit with optional single bounce back to Load.
// Q follows Start by one cycle; En=0 holds the run, Abort returns to IDLE without Done.
module updown_seq_ctrl
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Mode,
  input  logic             Bounce,
  input  logic [WIDTH-1:0] Load,
  input  logic [WIDTH-1:0] Limit,
  input  logic             En,
  input  logic             Abort,
  output logic [WIDTH-1:0] Q,
  output logic             Dir,
  output logic             Busy,
  output logic             Done
);

  seq_state_e       state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] load_q;
  logic             bounce_q;
  logic             bounced;

  logic             accept;
  logic             at_tgt;
  logic             step;
  logic             turn;

  assign accept = (state == IDLE) && Start;
  assign at_tgt = (Q == target);
  // Abort outranks everything in RUN, so it gates both the step and the turnaround.
  assign step   = (state == RUN) && !Abort && En && !at_tgt;
  assign turn   = (state == RUN) && !Abort && En && at_tgt && bounce_q && !bounced;

  updown_counter #(.WIDTH(WIDTH)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .Ld     (accept),
    .Ld_val (Load),
    .En     (step),
    .Up     (Dir),
    .Q      (Q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      Dir      <= DIR_UP;
      target   <= '0;
      load_q   <= '0;
      bounce_q <= 1'b0;
      bounced  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= RUN;
            Dir      <= Mode;
            target   <= Limit;
            load_q   <= Load;
            bounce_q <= Bounce;
            bounced  <= 1'b0;
          end
        end
        RUN: begin
          if (Abort) begin
            state <= IDLE;
          end else if (turn) begin
            Dir     <= ~Dir;
            target  <= load_q;
            bounced <= 1'b1;
          end else if (En && at_tgt) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Both flags decode the state register only, so no input reaches them combinationally.
  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed self-checking bench for updown_seq_ctrl at WIDTH=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_updown_seq_ctrl;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST, Start, Mode, Bounce, En, Abort;
  logic [W-1:0] Load, Limit, Q;
  logic         Dir, Busy, Done;

  int errs   = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  updown_seq_ctrl #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Start  (Start),
    .Mode   (Mode),
    .Bounce (Bounce),
    .Load   (Load),
    .Limit  (Limit),
    .En     (En),
    .Abort  (Abort),
    .Q      (Q),
    .Dir    (Dir),
    .Busy   (Busy),
    .Done   (Done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Issues Start for one cycle, then scrambles the operand inputs so latching is exercised.
  task automatic start_run(input logic m, input logic b, input logic [W-1:0] ld, input logic [W-1:0] lim);
    Start  = 1'b1;
    Mode   = m;
    Bounce = b;
    Load   = ld;
    Limit  = lim;
    tick();
    Start  = 1'b0;
    Mode   = ~m;
    Bounce = ~b;
    Load   = ~ld;
    Limit  = ~lim;
  endtask

  // Nibble i of qv and bit i of dv are the expected Q/Dir at cycle n+1+i; Done follows at n+1+len.
  task automatic check_seq(input string tag, input logic [31:0] qv, input logic [7:0] dv, input int len);
    logic [3:0] eq;
    for (int i = 0; i < len; i++) begin
      eq = qv[4*i +: 4];
      chk({tag, "_q"}, 32'(Q), 32'(eq));
      chk({tag, "_dir"}, 32'(Dir), 32'(dv[i]));
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_nodone"}, 32'(Done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_done_busy"}, 32'(Busy), 32'd1);
    tick();
    chk({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(Done), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; Start = 1'b1; Mode = 1'b0; Bounce = 1'b0; En = 1'b1; Abort = 1'b0;
    Load = 4'd7; Limit = 4'd9;
    tick();
    tick();
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_dir", 32'(Dir), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    RST = 1'b0; Start = 1'b0;
    tick();

    start_run(1'b1, 1'b0, 4'd3, 4'd6);
    check_seq("up", 32'h6543, 8'b1111, 4);

    start_run(1'b0, 1'b0, 4'd1, 4'd14);
    check_seq("down_wrap", 32'hEF01, 8'b0000, 4);

    start_run(1'b1, 1'b0, 4'd14, 4'd1);
    check_seq("up_wrap", 32'h10FE, 8'b1111, 4);

    start_run(1'b1, 1'b1, 4'd2, 4'd4);
    check_seq("bounce", 32'h234432, 8'b000111, 6);

    start_run(1'b1, 1'b0, 4'd5, 4'd5);
    check_seq("eq", 32'h5, 8'b1, 1);

    start_run(1'b1, 1'b1, 4'd5, 4'd5);
    check_seq("eq_bounce", 32'h55, 8'b01, 2);

    // Hold at n+2 and a stray Start at n+3 during an up run 0->3.
    start_run(1'b1, 1'b0, 4'd0, 4'd3);
    chk("hold_q1", 32'(Q), 32'd0);
    tick();
    chk("hold_q2", 32'(Q), 32'd1);
    En = 1'b0;
    tick();
    chk("hold_q3", 32'(Q), 32'd1);
    En = 1'b1; Start = 1'b1; Load = 4'd9; Mode = 1'b0;
    tick();
    Start = 1'b0;
    chk("hold_q4", 32'(Q), 32'd2);
    chk("hold_dir4", 32'(Dir), 32'd1);
    tick();
    chk("hold_q5", 32'(Q), 32'd3);
    chk("hold_nodone5", 32'(Done), 32'd0);
    tick();
    chk("hold_done6", 32'(Done), 32'd1);
    chk("hold_q6", 32'(Q), 32'd3);
    tick();
    chk("hold_idle7", 32'(Busy), 32'd0);

    // Abort at n+2 of a 0->7 run.
    start_run(1'b1, 1'b0, 4'd0, 4'd7);
    chk("abort_q1", 32'(Q), 32'd0);
    tick();
    chk("abort_q2", 32'(Q), 32'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_q", 32'(Q), 32'd1);
    chk("abort_nodone", 32'(Done), 32'd0);
    tick();
    chk("abort_nodone2", 32'(Done), 32'd0);
    chk("abort_qhold", 32'(Q), 32'd1);

    // Reset mid-run, with Start/En asserted alongside it.
    start_run(1'b0, 1'b0, 4'd9, 4'd2);
    tick();
    chk("mid_q", 32'(Q), 32'd8);
    chk("mid_dir", 32'(Dir), 32'd0);
    RST = 1'b1; Start = 1'b1; En = 1'b1;
    tick();
    RST = 1'b0; Start = 1'b0;
    chk("midrst_q", 32'(Q), 32'd0);
    chk("midrst_dir", 32'(Dir), 32'd1);
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    tick();
    chk("midrst_stay_idle", 32'(Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/updown_seq_ctrl.md
UPDOWN_SEQ_CTRL -- requirements
Module: updown_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port Start, input, 1 bit: command request, sampled only in IDLE.
REQ-005 SHALL have port Mode, input, 1 bit: initial direction (1 = up, 0 = down), latched on accepted Start.
REQ-006 SHALL have port Bounce, input, 1 bit: 1 = reverse once at Limit and return to Load; latched on accepted Start.
REQ-007 SHALL have port Load, input, WIDTH bits: start value, latched on accepted Start.
REQ-008 SHALL have port Limit, input, WIDTH bits: terminal value, latched on accepted Start.
REQ-009 SHALL have port En, input, 1 bit: count enable; 0 = hold.
REQ-010 SHALL have port Abort, input, 1 bit: terminate the run without Done.
REQ-011 SHALL have port Q, output, WIDTH bits: registered count value.
REQ-012 SHALL have port Dir, output, 1 bit: current direction (1 = up).
REQ-013 SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE, Start=1 at edge: Q<=Load, Dir<=Mode, target<=Limit, bounced flag<=0, state<=RUN; Q=Load visible one cycle after Start.
REQ-017 RUN, En=0: Q, Dir and target SHALL hold.
REQ-018 RUN, En=1, Q!=target: Q<=Q+1 (Dir=1) or Q-1 (Dir=0), modulo 2^WIDTH (15+1=0, 0-1=15 at WIDTH=4).
REQ-019 RUN, En=1, Q==target, Bounce latched and bounced flag=0: Dir<=~Dir, target<=latched Load, bounced flag<=1, Q held, stay RUN.
REQ-020 RUN, En=1, Q==target, otherwise: Q held, state<=DONE.
REQ-021 DONE: Done=1 for exactly this cycle, Q held; next state is IDLE unconditionally.
REQ-022 Abort=1 in RUN: state<=IDLE, Q held, no Done; Abort SHALL take priority over the equality checks and En.
REQ-023 Start outside IDLE SHALL be ignored; latched Load/Limit/Mode/Bounce SHALL NOT change during a run.
REQ-024 Load==Limit SHALL be legal: completion on the first enabled RUN cycle; with Bounce, one extra enabled cycle before completion.
REQ-025 Q, Dir, Busy and Done SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-026 On RST=1 at edge, from any state including mid-run: state=IDLE, Q=0, Dir=1, Busy=0, Done=0, bounced flag=0, target=0.
REQ-027 RST SHALL override Start, Abort and En in the same cycle.

Structure
REQ-028 Shared package updown_seq_pkg SHALL hold the FSM state enum and the DIR_UP=1 and DIR_DOWN=0 constants.
REQ-029 Sub-module updown_counter SHALL be used: a WIDTH-bit synchronous up/down counter with load, enable and direction, reset to 0; updown_seq_ctrl drives it.

Verification
(Start is asserted in cycle n, En=1 throughout unless stated.)
REQ-030 Up run, Mode=1, Load=3, Limit=6, Bounce=0 -> Q=3,4,5,6 at n+1..n+4; Done=1 only at n+5; Busy=1 for n+1..n+5; IDLE at n+6.
REQ-031 Down wrap, Mode=0, Load=1, Limit=14 -> Q=1,0,15,14 at n+1..n+4; Done=1 at n+5.
REQ-032 Bounce, Mode=1, Load=2, Limit=4, Bounce=1 -> Q=2,3,4,4,3,2 at n+1..n+6; Dir=0 from n+4; Done=1 at n+7.
REQ-033 Up run 0->3 with En=0 at n+2 and a second Start at n+3 (Load=9) -> Q=0,1,1,2,3 at n+1..n+5; second Start ignored; Done=1 at n+6.
REQ-034 Abort at n+2 in run 0->7 -> Q=1 held, Busy=0 at n+3, no Done; a later run with RST=1 mid-run -> next cycle Q=0, Dir=1, Busy=0, Done=0.
REQ-035 Load=Limit=5, Bounce=0 -> Q=5 at n+1, Done=1 at n+2.
